// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with an internal storage array, an occupancy counter, threshold flags
// and sticky error flags. The read port is either registered (standard) or fall-through (FWFT).
module sync_fifo_ctrl #(
    parameter int data_size       = 8,
    parameter int add_size        = 4,
    parameter int fwft            = 0,
    parameter int almost_full_th  = 14,
    parameter int almost_empty_th = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [data_size-1:0] data_in,
    input  logic                 rd_en,
    output logic [data_size-1:0] data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [add_size:0]    count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int DEPTH = 1 << add_size;

    typedef logic [add_size:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_TH   = cnt_t'(almost_full_th);
    localparam cnt_t AE_TH   = cnt_t'(almost_empty_th);

    logic [data_size-1:0] mem_q [DEPTH];

    cnt_t wr_ptr_q, wr_ptr_d;
    cnt_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q,  count_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic wr_acc, rd_acc;

    logic [add_size-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[add_size-1:0];
    assign rd_addr = rd_ptr_q[add_size-1:0];

    // Flags decode the registered count only, so they never depend on this cycle's requests.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + cnt_t'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + cnt_t'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // A new error in the same cycle as err_clr wins, so the flag ends set.
    always_comb begin
        ovf_d = err_clr ? 1'b0 : ovf_q;
        unf_d = err_clr ? 1'b0 : unf_q;
        if (wr_en && full)  ovf_d = 1'b1;
        if (rd_en && empty) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_addr] <= data_in;
    end

    // Pointer MSBs only distinguish full from empty laps; occupancy comes from count_q.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr_q[add_size] ^ rd_ptr_q[add_size];

    generate
        if (fwft == 0) begin : g_std
            logic [data_size-1:0] dout_q;
            logic                 dv_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) dout_q <= mem_q[rd_addr];
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end else begin : g_fwft
            // Head word is shown directly; zero while empty keeps the reset value clean.
            assign data_out   = empty ? '0 : mem_q[rd_addr];
            assign data_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one standard and one FWFT instance share stimulus and are
// checked against a queue scoreboard, a vector table and a few explicit corner sequences.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, err_clr;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.data_size(8), .add_size(4), .fwft(0), .almost_full_th(14), .almost_empty_th(2)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    sync_fifo_ctrl #(.data_size(8), .add_size(4), .fwft(1), .almost_full_th(14), .almost_empty_th(2)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    // Scoreboard: queue holds the words the FIFO should contain, in order.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic rd, input logic c,
                              input logic [7:0] d);
        int  cnt;
        logic wacc, racc;
        if (r) begin
            q.delete();
            m_dout = 8'h00;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            cnt  = q.size();
            wacc = w && (cnt != 16);
            racc = rd && (cnt != 0);
            m_dv = racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (w && cnt == 16) m_ovf = 1'b1;
            if (rd && cnt == 0) m_unf = 1'b1;
        end
    endtask

    task automatic check_model();
        int cnt;
        cnt = q.size();
        chk("count",        32'(s_count), 32'(cnt));
        chk("full",         32'(s_full),  32'(cnt == 16));
        chk("empty",        32'(s_empty), 32'(cnt == 0));
        chk("almost_full",  32'(s_af),    32'(cnt >= 14));
        chk("almost_empty", 32'(s_ae),    32'(cnt <= 2));
        chk("overflow",     32'(s_ovf),   32'(m_ovf));
        chk("underflow",    32'(s_unf),   32'(m_unf));
        chk("std_valid",    32'(s_dv),    32'(m_dv));
        chk("std_dout",     32'(s_dout),  32'(m_dout));
        chk("fwft_count",   32'(f_count), 32'(cnt));
        chk("fwft_valid",   32'(f_dv),    32'(cnt != 0));
        if (cnt != 0) chk("fwft_dout", 32'(f_dout), 32'(q[0]));
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic c,
                        input logic [7:0] d);
        rst = r; wr_en = w; rd_en = rd; err_clr = c; data_in = d;
        @(posedge clk);
        model_edge(r, w, rd, c, d);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       w, rd, c;
        logic [7:0] d;
        int         cnt;
        logic       ovf, unf;
    } vec_t;

    vec_t tv[6];

    initial begin
        // Underflow / clear corner cases starting from an empty FIFO.
        tv[0] = '{w:0, rd:1, c:0, d:8'h00, cnt:0, ovf:0, unf:1};
        tv[1] = '{w:0, rd:0, c:1, d:8'h00, cnt:0, ovf:0, unf:0};
        tv[2] = '{w:1, rd:1, c:0, d:8'h55, cnt:1, ovf:0, unf:1};
        tv[3] = '{w:0, rd:0, c:1, d:8'h00, cnt:1, ovf:0, unf:0};
        tv[4] = '{w:0, rd:1, c:0, d:8'h00, cnt:0, ovf:0, unf:0};
        tv[5] = '{w:1, rd:1, c:1, d:8'h66, cnt:1, ovf:0, unf:1};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("rst_empty",  32'(s_empty), 32'd1);
        chk("rst_ae",     32'(s_ae),    32'd1);
        chk("rst_full",   32'(s_full),  32'd0);
        chk("rst_count",  32'(s_count), 32'd0);
        chk("rst_dout",   32'(s_dout),  32'h00);
        chk("rst_errs",   32'({s_ovf, s_unf}), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, 8'(i));
            if (i == 14) chk("af_at_14", 32'(s_af), 32'd1);
        end
        chk("full_at_16", 32'(s_full), 32'd1);

        step(0, 1, 0, 0, 8'hAA);
        chk("ovf_set",   32'(s_ovf),   32'd1);
        chk("ovf_count", 32'(s_count), 32'd16);
        step(0, 0, 0, 1, 8'h00);
        chk("ovf_clr",   32'(s_ovf),   32'd0);

        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 0, 8'h00);
            chk("rd_order", 32'(s_dout), 32'(i));
            chk("rd_pulse", 32'(s_dv),   32'd1);
        end
        step(0, 0, 0, 0, 8'h00);
        chk("dv_drop",     32'(s_dv),    32'd0);
        chk("drain_empty", 32'(s_empty), 32'd1);

        for (int i = 0; i < 6; i++) begin
            step(0, tv[i].w, tv[i].rd, tv[i].c, tv[i].d);
            chk("tv_count", 32'(s_count), 32'(tv[i].cnt));
            chk("tv_ovf",   32'(s_ovf),   32'(tv[i].ovf));
            chk("tv_unf",   32'(s_unf),   32'(tv[i].unf));
        end
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 8'h00);

        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 1, 0, 8'(8'h80 + i));
            chk("wrap_count", 32'(s_count), 32'd8);
        end
        chk("wrap_errs", 32'({s_ovf, s_unf}), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'h00);

        step(0, 1, 0, 0, 8'h3C);
        chk("fwft_first_dout",  32'(f_dout), 32'h3C);
        chk("fwft_first_valid", 32'(f_dv),   32'd1);
        step(0, 0, 1, 0, 8'h00);
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_pop_valid", 32'(f_dv),    32'd0);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(8'hC0 + i));
        chk("pre_rst_count", 32'(s_count), 32'd5);
        step(1, 1, 1, 0, 8'hEE);
        chk("rst5_count", 32'(s_count), 32'd0);
        chk("rst5_empty", 32'(s_empty), 32'd1);
        chk("rst5_dout",  32'(s_dout),  32'h00);
        chk("rst5_dv",    32'(s_dv),    32'd0);
        chk("rst5_fdv",   32'(f_dv),    32'd0);
        step(0, 0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO with a built-in storage array, occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It is the single-clock successor to the team's dual-port FIFO memory: it adds pointer and flag management, and selects standard or first-word-fall-through (FWFT) read mode by parameter. It is used wherever producer and consumer share one clock domain, for example for rate buffering between pipeline stages.

Parameters:
data_size, 8, data word width in bits
add_size, 4, address bits; DEPTH = 1<<add_size
fwft, 0, 0 = standard registered read; 1 = first-word-fall-through
almost_full_th, 14, almost_full asserts when count >= this value (1..DEPTH)
almost_empty_th, 2, almost_empty asserts when count <= this value (0..DEPTH-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
data_in  in  data_size  write data
rd_en  in  1  read request / pop
data_out  out  data_size  read data
data_valid  out  1  standard mode: data_out updated this cycle; FWFT mode: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= almost_full_th
almost_empty  out  1  count <= almost_empty_th
count  out  add_size+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, data_valid=0, overflow=0, underflow=0. Memory contents are not reset. rst overrides every other input in that cycle, and any read or write in flight is discarded.
- Pointers are add_size+1 bits wide.
  - The address is the low add_size bits.
  - Both pointers wrap naturally from DEPTH-1 to 0, with the MSB toggling.
  - count is a registered up/down counter and must always equal wr_ptr - rd_ptr, modulo 2^(add_size+1).
- Accept rules, evaluated on the flag values present at the clock edge:
  - Write is accepted iff wr_en && !full: mem[wr_ptr] <= data_in, then wr_ptr increments.
  - Read is accepted iff rd_en && !empty: rd_ptr increments.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full with wr_en && rd_en: the read is accepted, the write is rejected, and overflow is set.
  - When empty with wr_en && rd_en: the write is accepted, the read is rejected, and underflow is set.
- All flags are combinational decodes of the registered count, so they change in the cycle after the accepting edge.
- Standard mode (fwft=0):
  - On an accepted read, data_out <= mem[rd_ptr] at that edge; latency is one clock from rd_en sampled to data valid.
  - data_valid is a one-cycle pulse aligned with the new data_out.
  - data_out holds its value when no read is accepted.
- FWFT mode (fwft=1):
  - data_out presents mem[rd_ptr] whenever !empty; rd_en acts as an acknowledge/pop.
  - After a pop, the next word appears in the following cycle.
  - The first write into an empty FIFO is visible at data_out with data_valid=1 one clock after the write edge.
  - When empty, data_out value is don't-care and data_valid=0.
- Error flags:
  - overflow is set on wr_en && full; underflow is set on rd_en && empty.
  - Both hold until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the flag ends set.
- Rejected operations never alter pointers, count or memory.

Test Plan (data_size=8, add_size=4, DEPTH=16, thresholds 14/2):
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, data_out=0x00, all error flags 0.
- fwft=0: write 0x01..0x10 (16 words), then read 16 -> full=1 after the 16th write; almost_full=1 at count=14; reads return 0x01..0x10 in order, each with a 1-cycle data_valid pulse; empty=1 at the end.
- Full plus a 17th write of 0xAA -> overflow=1, count stays 16, 0xAA is never read out; err_clr for one cycle -> overflow=0.
- Empty with rd_en=1 -> underflow=1, count stays 0, pointers unchanged. Empty with wr_en=rd_en=1 and data 0x55 -> count=1, underflow=1.
- Wrap-around: run 40 write/read pairs concurrently starting at count=8 -> count stays 8, data order is preserved across the pointer wrap, no error flags set.
- fwft=1: write 0x3C into an empty FIFO -> next cycle data_out=0x3C, data_valid=1 with no rd_en; pop -> empty=1. Separately, assert rst at count=5 -> the next cycle shows all reset values.
